// File: rtl/icache_pkg.sv
// Shared defaults, derived field widths and FSM state type for the instruction cache.
package icache_pkg;

    localparam int NUM_LINES_DEF      = 16;
    localparam int WORDS_PER_LINE_DEF = 4;

    localparam int OFFSET_W_DEF = $clog2(WORDS_PER_LINE_DEF);
    localparam int INDEX_W_DEF  = $clog2(NUM_LINES_DEF);
    localparam int TAG_W_DEF    = 32 - INDEX_W_DEF - OFFSET_W_DEF - 2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REFILL    = 2'd1,
        ST_FILL_DONE = 2'd2
    } state_e;

    // Tag width left over once byte, word-offset and index bits are taken from a 32-bit PC.
    function automatic int tag_width(int num_lines, int words_per_line);
        return 32 - $clog2(num_lines) - $clog2(words_per_line) - 2;
    endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and refill-side signals of the instruction cache, bundled as one bus.
interface icache_if;

    logic [31:0] PC;
    logic        flush;
    logic [31:0] inst;
    logic        is_cache_missed;
    logic        mem_rd_req;
    logic [31:0] mem_addr;
    logic        mem_rd_valid;
    logic [31:0] mem_rd_data;

    modport slave (
        input  PC, flush, mem_rd_valid, mem_rd_data,
        output inst, is_cache_missed, mem_rd_req, mem_addr
    );

    modport master (
        output PC, flush, mem_rd_valid, mem_rd_data,
        input  inst, is_cache_missed, mem_rd_req, mem_addr
    );

endinterface

// File: rtl/icache_data_ram.sv
// Instruction data store: one 32-bit word per entry, combinational read, clocked write.
module icache_data_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Refill beats land here; contents are never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller with zero-latency hit and in-order line refill.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | lookup at current PC; a miss latches the line and starts refill
// ST_REFILL    | mem_rd_req high, each mem_rd_valid beat written at beat_cnt
// ST_FILL_DONE | tag written, line validated unless a flush hit mid-refill
module icache_ctrl
    import icache_pkg::*;
#(
    parameter int NUM_LINES      = NUM_LINES_DEF,
    parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF
) (
    input  logic     clk,
    input  logic     rst_b,
    icache_if.slave  bus
);

    localparam int OFF_W  = $clog2(WORDS_PER_LINE);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = tag_width(NUM_LINES, WORDS_PER_LINE);
    localparam int RAM_AW = IDX_W + OFF_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

    state_e               state_q;
    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_mem [NUM_LINES];
    logic [TAG_W-1:0]     tag_lat_q;
    logic [IDX_W-1:0]     idx_lat_q;
    logic [OFF_W-1:0]     beat_cnt_q;
    logic                 discard_q;
    logic                 mem_rd_req_q;
    logic [31:0]          mem_addr_q;

    logic [OFF_W-1:0]     pc_off;
    logic [IDX_W-1:0]     pc_idx;
    logic [TAG_W-1:0]     pc_tag;
    logic                 hit;
    logic                 ram_we;
    logic [31:0]          ram_rdata;
    logic                 unused_pc_lsb;

    assign pc_off        = bus.PC[OFF_W+1:2];
    assign pc_idx        = bus.PC[OFF_W+IDX_W+1:OFF_W+2];
    assign pc_tag        = bus.PC[31:OFF_W+IDX_W+2];
    assign unused_pc_lsb = ^bus.PC[1:0];

    // A flush cycle never serves a fetch, even if the line is present.
    assign hit    = (state_q == ST_IDLE) && !bus.flush && valid_q[pc_idx] && (tag_mem[pc_idx] == pc_tag);
    assign ram_we = (state_q == ST_REFILL) && bus.mem_rd_valid;

    icache_data_ram #(
        .DEPTH (NUM_LINES * WORDS_PER_LINE),
        .AW    (RAM_AW)
    ) u_data_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr ({idx_lat_q, beat_cnt_q}),
        .wdata (bus.mem_rd_data),
        .raddr ({pc_idx, pc_off}),
        .rdata (ram_rdata)
    );

    assign bus.is_cache_missed = !hit;
    assign bus.inst            = hit ? ram_rdata : 32'h0;
    assign bus.mem_rd_req      = mem_rd_req_q;
    assign bus.mem_addr        = mem_addr_q;

    // Tags are only written once the whole line has arrived; not reset.
    always_ff @(posedge clk) begin
        if (state_q == ST_FILL_DONE) begin
            tag_mem[idx_lat_q] <= tag_lat_q;
        end
    end

    // Refill sequencing, valid bits and registered memory-side outputs.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= ST_IDLE;
            valid_q      <= '0;
            tag_lat_q    <= '0;
            idx_lat_q    <= '0;
            beat_cnt_q   <= '0;
            discard_q    <= 1'b0;
            mem_rd_req_q <= 1'b0;
            mem_addr_q   <= 32'h0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.flush) begin
                        valid_q <= '0;
                    end else if (!hit) begin
                        tag_lat_q    <= pc_tag;
                        idx_lat_q    <= pc_idx;
                        mem_addr_q   <= {pc_tag, pc_idx, {(OFF_W + 2){1'b0}}};
                        mem_rd_req_q <= 1'b1;
                        state_q      <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    if (bus.flush) begin
                        valid_q   <= '0;
                        discard_q <= 1'b1;
                    end
                    if (bus.mem_rd_valid) begin
                        beat_cnt_q <= beat_cnt_q + OFF_W'(1);
                        if (beat_cnt_q == LAST_BEAT) begin
                            mem_rd_req_q <= 1'b0;
                            state_q      <= ST_FILL_DONE;
                        end
                    end
                end
                ST_FILL_DONE: begin
                    if (bus.flush) begin
                        valid_q <= '0;
                    end else if (!discard_q) begin
                        valid_q[idx_lat_q] <= 1'b1;
                    end
                    beat_cnt_q <= '0;
                    discard_q  <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench: directed scenarios plus random fetches against a line-level cache model.
module tb_icache_ctrl;
    import icache_pkg::*;

    localparam int NL  = 16;
    localparam int WPL = 4;

    logic clk = 1'b0;
    logic rst_b;

    always #5 clk = ~clk;

    icache_if bus_if();

    icache_ctrl #(
        .NUM_LINES      (NL),
        .WORDS_PER_LINE (WPL)
    ) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    bit          m_valid [NL];
    logic [31:0] m_tag   [NL];
    logic [31:0] m_data  [NL][WPL];
    logic [31:0] mem_img [logic [31:0]];

    function automatic logic [31:0] mem_word(logic [31:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
    endfunction

    function automatic int f_idx(logic [31:0] pc);
        return int'((pc / 32'(4 * WPL)) % 32'(NL));
    endfunction

    function automatic int f_off(logic [31:0] pc);
        return int'((pc / 32'd4) % 32'(WPL));
    endfunction

    function automatic logic [31:0] f_tag(logic [31:0] pc);
        return pc / 32'(4 * WPL * NL);
    endfunction

    task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_flush();
        for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] pc, output bit was_hit);
        int idx;
        int off;
        bus_if.PC           = pc;
        bus_if.flush        = 1'b0;
        bus_if.mem_rd_valid = 1'b0;
        #1;
        idx     = f_idx(pc);
        off     = f_off(pc);
        was_hit = m_valid[idx] && (m_tag[idx] == f_tag(pc));
        chk("lookup_miss", {31'b0, bus_if.is_cache_missed}, {31'b0, !was_hit});
        chk("lookup_inst", bus_if.inst, was_hit ? m_data[idx][off] : 32'h0);
    endtask

    // One fetch; on a miss run the whole refill, then re-look up at pc_after.
    task automatic access(input logic [31:0] pc, input int gap, input int flush_beat,
                          input logic [31:0] pc_after);
        bit          was_hit;
        bit          flushed;
        logic [31:0] base;
        int          idx;
        flushed = 1'b0;
        lookup(pc, was_hit);
        if (was_hit) return;
        base = pc - (pc % 32'(4 * WPL));
        idx  = f_idx(pc);
        bus_if.mem_rd_valid = 1'($urandom_range(0, 1));
        bus_if.mem_rd_data  = $urandom;
        step();
        chk("req_start", {31'b0, bus_if.mem_rd_req}, 32'd1);
        chk("addr_start", bus_if.mem_addr, base);
        for (int b = 0; b < WPL; b++) begin
            int g;
            g = (b == 0) ? 0 : ((gap < 0) ? int'($urandom_range(0, 3)) : gap);
            for (int k = 0; k < g; k++) begin
                bus_if.mem_rd_valid = 1'b0;
                bus_if.mem_rd_data  = $urandom;
                bus_if.PC           = $urandom & 32'hFFFF_FFFC;
                step();
                chk("gap_req", {31'b0, bus_if.mem_rd_req}, 32'd1);
                chk("gap_addr", bus_if.mem_addr, base);
                chk("gap_miss", {31'b0, bus_if.is_cache_missed}, 32'd1);
            end
            bus_if.mem_rd_valid = 1'b1;
            bus_if.mem_rd_data  = mem_word(base + 32'(4 * b));
            bus_if.flush        = (b == flush_beat);
            bus_if.PC           = $urandom & 32'hFFFF_FFFC;
            if (b == flush_beat) begin
                flushed = 1'b1;
                model_flush();
            end
            step();
            bus_if.flush        = 1'b0;
            bus_if.mem_rd_valid = 1'b0;
            if (b < WPL - 1) begin
                chk("beat_req", {31'b0, bus_if.mem_rd_req}, 32'd1);
                chk("beat_addr", bus_if.mem_addr, base);
            end else begin
                chk("req_drop", {31'b0, bus_if.mem_rd_req}, 32'd0);
            end
            chk("beat_miss", {31'b0, bus_if.is_cache_missed}, 32'd1);
            chk("beat_inst", bus_if.inst, 32'h0);
        end
        // Stray beat in the fill-done cycle must not touch the line.
        bus_if.mem_rd_valid = 1'($urandom_range(0, 1));
        bus_if.mem_rd_data  = $urandom;
        step();
        bus_if.mem_rd_valid = 1'b0;
        if (!flushed) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = f_tag(pc);
            for (int w = 0; w < WPL; w++) m_data[idx][w] = mem_word(base + 32'(4 * w));
        end
        lookup(pc_after, was_hit);
    endtask

    task automatic idle_flush(input logic [31:0] pc);
        bus_if.PC           = pc;
        bus_if.flush        = 1'b1;
        bus_if.mem_rd_valid = 1'b0;
        #1;
        chk("flush_miss", {31'b0, bus_if.is_cache_missed}, 32'd1);
        chk("flush_inst", bus_if.inst, 32'h0);
        step();
        bus_if.flush = 1'b0;
        model_flush();
    endtask

    function automatic logic [31:0] rand_pc();
        return (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, NL - 1)) << 4) |
               (32'($urandom_range(0, WPL - 1)) << 2);
    endfunction

    initial begin
        logic [31:0] pc;
        int          fb;
        rst_b               = 1'b0;
        bus_if.PC           = 32'h0;
        bus_if.flush        = 1'b0;
        bus_if.mem_rd_valid = 1'b0;
        bus_if.mem_rd_data  = 32'h0;
        mem_img[32'h0]      = 32'h11;
        mem_img[32'h4]      = 32'h22;
        mem_img[32'h8]      = 32'h33;
        mem_img[32'hC]      = 32'h44;
        model_flush();
        for (int i = 0; i < NL; i++) m_tag[i] = 32'hFFFF_FFFF;

        step();
        step();
        chk("rst_miss", {31'b0, bus_if.is_cache_missed}, 32'd1);
        chk("rst_inst", bus_if.inst, 32'h0);
        chk("rst_req", {31'b0, bus_if.mem_rd_req}, 32'd0);
        chk("rst_addr", bus_if.mem_addr, 32'h0);
        rst_b = 1'b1;

        access(32'h0, 0, -1, 32'h8);
        chk("dir_inst_0x8", bus_if.inst, 32'h33);
        access(32'h100, 3, -1, 32'h104);
        access(32'h4, -1, 1, 32'h4);
        chk("dir_flush_miss", {31'b0, bus_if.is_cache_missed}, 32'd1);
        access(32'h4, -1, -1, 32'h4);
        chk("dir_refetch_inst", bus_if.inst, 32'h22);

        // Reset in the middle of a burst.
        bus_if.PC = 32'h200;
        #1;
        chk("rr_miss", {31'b0, bus_if.is_cache_missed}, 32'd1);
        step();
        chk("rr_addr", bus_if.mem_addr, 32'h200);
        for (int b = 0; b < 2; b++) begin
            bus_if.mem_rd_valid = 1'b1;
            bus_if.mem_rd_data  = $urandom;
            step();
        end
        rst_b = 1'b0;
        #1;
        model_flush();
        chk("rr_req", {31'b0, bus_if.mem_rd_req}, 32'd0);
        chk("rr_addr0", bus_if.mem_addr, 32'h0);
        chk("rr_miss_in_rst", {31'b0, bus_if.is_cache_missed}, 32'd1);
        step();
        rst_b = 1'b1;
        access(32'h0, -1, -1, 32'h0);
        access(32'h200, -1, -1, 32'h204);

        for (int n = 0; n < 60; n++) begin
            pc = rand_pc();
            if ($urandom_range(0, 9) == 0) begin
                idle_flush(pc);
            end else begin
                fb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, WPL - 1)) : -1;
                access(pc, -1, fb, ($urandom_range(0, 1) == 0) ? pc : rand_pc());
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_ctrl.md
ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 Parameter NUM_LINES, 16, number of direct-mapped cache lines (power of two).
REQ-002 Parameter WORDS_PER_LINE, 4, 32-bit words per line (power of two); refill burst length.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_b  input  1  reset, asynchronous, active-low.
REQ-005 PC  input  32  fetch address from the IF stage; word-aligned, PC[1:0] ignored.
REQ-006 flush  input  1  invalidate all lines.
REQ-007 inst  output  32  fetched instruction; valid when is_cache_missed is 0.
REQ-008 is_cache_missed  output  1  fetch at PC not served this cycle; IF stage holds PC.
REQ-009 mem_rd_req  output  1  refill request to instruction memory.
REQ-010 mem_addr  output  32  line-aligned refill base address.
REQ-011 mem_rd_valid  input  1  one refill data beat present this cycle.
REQ-012 mem_rd_data  input  32  refill data beat.

Function
REQ-013 Address split (defaults): offset PC[3:2], index PC[7:4], tag PC[31:8]; widths derive from parameters.
REQ-014 Hit = line valid and stored tag equals PC tag, evaluated combinationally in IDLE; hit latency 0 cycles.
REQ-015 inst = data word at {index, offset} on hit; 32'h0 whenever is_cache_missed is 1.
REQ-016 is_cache_missed = 1 whenever state is not IDLE, or state is IDLE and no hit.
REQ-017 FSM states IDLE, REFILL, FILL_DONE.
REQ-018 IDLE -> REFILL on miss (no flush): latch tag/index, mem_addr <= {tag, index, offset zeros}.
REQ-019 In REFILL: mem_rd_req = 1; mem_addr constant; each mem_rd_valid writes mem_rd_data to word beat_cnt of latched line and increments beat_cnt.
REQ-020 beat_cnt width log2(WORDS_PER_LINE); beats arrive in order word 0 first; last beat (beat_cnt == WORDS_PER_LINE-1 with mem_rd_valid) -> FILL_DONE, mem_rd_req drops next cycle.
REQ-021 mem_rd_valid outside REFILL is ignored.
REQ-022 FILL_DONE: write tag, set valid (unless discard set), clear beat_cnt and discard; -> IDLE; hit visible in the following IDLE cycle.
REQ-023 Miss-to-hit: WORDS_PER_LINE beats + 2 cycles after last memory beat counting FILL_DONE and the IDLE re-lookup.
REQ-024 PC changes during REFILL/FILL_DONE do not alter the refill; lookup in IDLE uses the current PC.
REQ-025 flush in IDLE clears all valid bits next edge; is_cache_missed = 1 in the flush cycle.
REQ-026 flush in REFILL or FILL_DONE clears all valid bits and sets discard; burst runs to completion; line left invalid.
REQ-027 Valid bit never set for a partially filled line.

Reset
REQ-028 rst_b low: state IDLE, all valid bits 0, beat_cnt 0, discard 0, mem_rd_req 0, mem_addr 32'h0, immediately.
REQ-029 Output values in reset: is_cache_missed 1, inst 32'h0.
REQ-030 Reset mid-refill abandons the burst; no line becomes valid; later beats ignored.
REQ-031 Tag and data arrays not reset.

Structure
REQ-032 Package icache_pkg holds NUM_LINES/WORDS_PER_LINE defaults, derived field widths, state enum.
REQ-033 One sub-module icache_data_ram: NUM_LINES*WORDS_PER_LINE x 32, async read, sync write.
REQ-034 Tags, valid bits, FSM stay in icache_ctrl.

Verification
REQ-035 Reset release, PC=0x0 -> is_cache_missed=1, mem_rd_req=1 next cycle, mem_addr=0x0.
REQ-036 Beats 0x11,0x22,0x33,0x44 on 4 consecutive cycles, PC=0x8 -> FILL_DONE, then inst=0x33, is_cache_missed=0.
REQ-037 PC=0x100 after line 0 filled with tag 0 -> miss (tag conflict), mem_addr=0x100.
REQ-038 Beats with gaps (mem_rd_valid low 3 cycles between beats) -> mem_rd_req stays 1, mem_addr stable, correct word placement.
REQ-039 flush during 2nd refill beat -> burst completes, PC=0x4 still misses, new refill at 0x0.
REQ-040 rst_b low after 2 beats -> mem_rd_req 0 immediately; after release PC=0x0 misses again.
